// File: rtl/icache_assoc_pkg.sv
// rtl/icache_assoc_pkg.sv - shared cache state type and address-split helper
package icache_assoc_pkg;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} icache_state_t;

  // Extracts a width-bit field starting at lsb; shared with the dcache split.
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    return (addr >> lsb) & mask[31:0];
  endfunction

endpackage

// File: rtl/icache_way.sv
// rtl/icache_way.sv - one way: valid/tag/data arrays, combinational lookup, single write port
module icache_way
  import icache_assoc_pkg::*;
#(
  parameter int SETS  = 16,
  parameter int WORDS = 2,
  parameter int TAG_W = 27,
  localparam int IDX_W  = $clog2(SETS),
  localparam int WOFF_S = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic [WOFF_S-1:0] rd_woff,
  output logic              rd_valid,
  output logic              rd_match,
  output logic [31:0]       rd_data,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WOFF_S-1:0] wr_woff,
  input  logic [31:0]       wr_data,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_en,
  input  logic              wr_install,
  input  logic              wr_inval
);

  logic [SETS-1:0]             valid;
  logic [TAG_W-1:0]            tags [SETS];
  logic [WORDS-1:0][31:0]      data [SETS];

  assign rd_valid = valid[rd_idx];
  assign rd_match = valid[rd_idx] && (tags[rd_idx] == rd_tag);
  assign rd_data  = data[rd_idx][rd_woff];

  always_ff @(posedge clk) begin
    if (wr_en)      data[wr_idx][wr_woff] <= wr_data;
    if (wr_install) tags[wr_idx] <= wr_tag;
  end

  always_ff @(posedge clk) begin
    if (rst)             valid <= '0;
    else if (wr_install) valid[wr_idx] <= 1'b1;
    else if (wr_inval)   valid[wr_idx] <= 1'b0;
  end

endmodule

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - set-associative icache with block fill, round-robin replacement and flush sweep
module icache_assoc
  import icache_assoc_pkg::*;
#(
  parameter int SETS          = 16,
  parameter int WAYS          = 2,
  parameter int WORDS_PER_BLK = 2,
  parameter int CNT_W         = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  input  logic             flush,
  output logic             flushed,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IDX    = $clog2(SETS);
  localparam int WOFF   = $clog2(WORDS_PER_BLK);
  localparam int WOFF_S = (WOFF > 0) ? WOFF : 1;
  localparam int TAG_W  = 30 - WOFF - IDX;
  localparam int BLK_W  = 30 - WOFF;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  icache_state_t     state;
  logic [IDX-1:0]    idx, fill_idx, sweep;
  logic [TAG_W-1:0]  tag, fill_tag;
  logic [WOFF_S-1:0] woff, wcnt;
  logic [BLK_W-1:0]  fill_blk;
  logic [PTR_W-1:0]  ptr [SETS];
  logic [PTR_W-1:0]  victim, fill_way;
  logic [WAYS-1:0]   way_valid, way_match;
  logic [31:0]       way_data [WAYS];
  logic              miss, fill_done;

  assign idx  = IDX'(addr_field(imemaddr, 2 + WOFF, IDX));
  assign tag  = TAG_W'(addr_field(imemaddr, 2 + WOFF + IDX, TAG_W));
  assign woff = WOFF_S'(addr_field(imemaddr, 2, WOFF));

  assign ihit      = (state == IDLE) && imemREN && (|way_match);
  assign miss      = (state == IDLE) && imemREN && !(|way_match);
  assign fill_done = (state == FILL) && !iwait && (wcnt == WOFF_S'(WORDS_PER_BLK - 1));
  assign iREN      = (state == FILL);
  assign iaddr     = iREN ? ((32'(fill_blk) << (WOFF + 2)) | (32'(wcnt) << 2)) : '0;

  // Lowest invalid way wins; the round-robin pointer only matters for a full set.
  always_comb begin
    victim = ptr[idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!way_valid[w]) victim = PTR_W'(w);
  end

  always_comb begin
    imemload = '0;
    for (int w = 0; w < WAYS; w++)
      if (ihit && way_match[w]) imemload = imemload | way_data[w];
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(.SETS(SETS), .WORDS(WORDS_PER_BLK), .TAG_W(TAG_W)) u_way (
      .clk        (CLK),
      .rst        (RST),
      .rd_idx     (idx),
      .rd_tag     (tag),
      .rd_woff    (woff),
      .rd_valid   (way_valid[w]),
      .rd_match   (way_match[w]),
      .rd_data    (way_data[w]),
      .wr_idx     ((state == FLUSH) ? sweep : fill_idx),
      .wr_woff    (wcnt),
      .wr_data    (iload),
      .wr_tag     (fill_tag),
      .wr_en      ((state == FILL) && !iwait && (fill_way == PTR_W'(w))),
      .wr_install (fill_done && (fill_way == PTR_W'(w))),
      .wr_inval   (state == FLUSH)
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wcnt       <= '0;
      sweep      <= '0;
      flushed    <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
      fill_idx   <= '0;
      fill_tag   <= '0;
      fill_blk   <= '0;
      fill_way   <= '0;
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    end else begin
      flushed <= 1'b0;
      if (ihit && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
      case (state)
        IDLE: begin
          if (flush) begin
            state <= FLUSH;
            sweep <= '0;
          end else if (miss) begin
            state    <= FILL;
            fill_blk <= imemaddr[31 -: BLK_W];
            fill_idx <= idx;
            fill_tag <= tag;
            fill_way <= victim;
            wcnt     <= '0;
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
          end
        end
        FILL: begin
          if (!iwait) begin
            wcnt <= wcnt + WOFF_S'(1);
            if (fill_done) begin
              state <= IDLE;
              if (fill_way == ptr[fill_idx])
                ptr[fill_idx] <= (WAYS == 1) ? '0 : fill_way + PTR_W'(1);
            end
          end
        end
        FLUSH: begin
          ptr[sweep] <= '0;
          sweep      <= sweep + IDX'(1);
          if (sweep == IDX'(SETS - 1)) begin
            state   <= IDLE;
            flushed <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
